// File: rtl/counter999_if.sv
// Command/status bundle for the three-digit BCD counter controller.
interface counter999_if;
    logic        start;
    logic        stop;
    logic        clear;
    logic        auto_reload;
    logic [11:0] target;
    logic [3:0]  q1;
    logic [3:0]  q2;
    logic [3:0]  q3;
    logic        busy;
    logic        done;
    logic        wrap;
    logic        target_err;

    // Master issues commands and target, slave (the counter) reports status.
    modport master (
        output start, stop, clear, auto_reload, target,
        input  q1, q2, q3, busy, done, wrap, target_err
    );

    modport slave (
        input  start, stop, clear, auto_reload, target,
        output q1, q2, q3, busy, done, wrap, target_err
    );
endinterface

// File: rtl/counter999_ctrl.sv
// Three-digit BCD up-counter (000..999) with prescaler, pause/resume,
// terminal-value match and optional auto-reload.
module counter999_ctrl #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic         clk,
    input  logic         rst,
    counter999_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [1:0]  state;
    logic [15:0] presc;
    logic [3:0]  q1, q2, q3;
    logic        done_r, wrap_r, terr_r;
    // Set by an auto-reload match: the next tick loads 000 instead of counting.
    logic        reload_pend;

    logic        tick, carry1, carry2, all_nine, match, target_bad;
    logic [3:0]  n1, n2, n3;

    // BCD increment of the current count, rollover detect and target match.
    always_comb begin
        tick       = (presc == PRE_LAST);
        carry1     = (q1 == 4'd9);
        carry2     = carry1 && (q2 == 4'd9);
        n1         = carry1 ? 4'd0 : q1 + 4'd1;
        n2         = carry1 ? ((q2 == 4'd9) ? 4'd0 : q2 + 4'd1) : q2;
        n3         = carry2 ? ((q3 == 4'd9) ? 4'd0 : q3 + 4'd1) : q3;
        all_nine   = carry2 && (q3 == 4'd9);
        // Only the post-increment value is compared, so a start-load of 000
        // can never match; an illegal target can never match either.
        match      = ({n3, n2, n1} == bus.target);
        target_bad = (bus.target[3:0] > 4'd9) || (bus.target[7:4] > 4'd9) ||
                     (bus.target[11:8] > 4'd9);
    end

    // Control FSM, prescaler, digits and pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            presc       <= '0;
            q1          <= '0;
            q2          <= '0;
            q3          <= '0;
            done_r      <= 1'b0;
            wrap_r      <= 1'b0;
            terr_r      <= 1'b0;
            reload_pend <= 1'b0;
        end else begin
            done_r <= 1'b0;
            wrap_r <= 1'b0;
            terr_r <= target_bad;
            if (bus.clear) begin
                state       <= S_IDLE;
                presc       <= '0;
                q1          <= '0;
                q2          <= '0;
                q3          <= '0;
                reload_pend <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        // stop has nothing to pause here; start needs a legal target.
                        if (bus.start && !bus.stop && !terr_r) begin
                            state       <= S_RUN;
                            presc       <= '0;
                            q1          <= '0;
                            q2          <= '0;
                            q3          <= '0;
                            reload_pend <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (bus.stop) begin
                            state <= S_PAUSE;
                        end else if (tick) begin
                            presc <= '0;
                            if (reload_pend) begin
                                q1          <= '0;
                                q2          <= '0;
                                q3          <= '0;
                                reload_pend <= 1'b0;
                            end else begin
                                q1     <= n1;
                                q2     <= n2;
                                q3     <= n3;
                                wrap_r <= all_nine;
                                if (match) begin
                                    done_r <= 1'b1;
                                    if (bus.auto_reload) reload_pend <= 1'b1;
                                    else                 state       <= S_DONE;
                                end
                            end
                        end else begin
                            presc <= presc + 16'd1;
                        end
                    end
                    S_PAUSE: begin
                        if (bus.start && !bus.stop) state <= S_RUN;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.q1         = q1;
    assign bus.q2         = q2;
    assign bus.q3         = q3;
    assign bus.busy       = (state == S_RUN) || (state == S_PAUSE);
    assign bus.done       = done_r;
    assign bus.wrap       = wrap_r;
    assign bus.target_err = terr_r;
endmodule

// File: tb/tb_counter999_ctrl.sv
// Scoreboard bench: two counters (PRESCALE 1 and 3) share stimulus; an
// integer-level reference model predicts each post-edge observation.
module tb_counter999_ctrl;
    typedef struct packed {
        logic [11:0] q;
        logic        busy;
        logic        done;
        logic        wrap;
        logic        terr;
    } obs_t;
    typedef obs_t [1:0] pair_t;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    counter999_if bus0 ();
    counter999_if bus1 ();

    counter999_ctrl #(.PRESCALE(1)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    counter999_ctrl #(.PRESCALE(3)) u1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    pair_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle_no = 0;

    // Reference model state: count as a plain integer 0..999.
    int          pre_n [2] = '{1, 3};
    int          m_state [2];
    int          m_cnt [2];
    int          m_pre [2];
    bit          m_reload [2];
    bit          m_terr [2];

    logic [11:0] cur_tgt = 12'h000;
    bit          cur_ar = 1'b0;

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic model_reset(input int k);
        m_state[k] = M_IDLE; m_cnt[k] = 0; m_pre[k] = 0;
        m_reload[k] = 1'b0;  m_terr[k] = 1'b0;
    endtask

    task automatic model_step(input int k, input bit r, input bit s, input bit p,
                              input bit c, input bit a, input logic [11:0] t,
                              output obs_t o);
        bit dn = 1'b0, wr = 1'b0;
        bit bad = (t[3:0] > 9) || (t[7:4] > 9) || (t[11:8] > 9);
        int tv = bad ? -1 : int'(t[11:8]) * 100 + int'(t[7:4]) * 10 + int'(t[3:0]);
        if (r) begin
            model_reset(k);
        end else begin
            if (c) begin
                m_state[k] = M_IDLE; m_cnt[k] = 0; m_pre[k] = 0; m_reload[k] = 1'b0;
            end else if (m_state[k] == M_IDLE || m_state[k] == M_DONE) begin
                if (s && !p && !m_terr[k]) begin
                    m_state[k] = M_RUN; m_cnt[k] = 0; m_pre[k] = 0; m_reload[k] = 1'b0;
                end
            end else if (m_state[k] == M_RUN) begin
                if (p) m_state[k] = M_PAUSE;
                else if (m_pre[k] == pre_n[k] - 1) begin
                    m_pre[k] = 0;
                    if (m_reload[k]) begin
                        m_cnt[k] = 0; m_reload[k] = 1'b0;
                    end else begin
                        m_cnt[k] = (m_cnt[k] + 1) % 1000;
                        wr = (m_cnt[k] == 0);
                        if (m_cnt[k] == tv) begin
                            dn = 1'b1;
                            if (a) m_reload[k] = 1'b1;
                            else   m_state[k] = M_DONE;
                        end
                    end
                end else m_pre[k] = m_pre[k] + 1;
            end else if (m_state[k] == M_PAUSE) begin
                if (s && !p) m_state[k] = M_RUN;
            end
            m_terr[k] = bad;
        end
        o.q    = to_bcd(m_cnt[k]);
        o.busy = (m_state[k] == M_RUN) || (m_state[k] == M_PAUSE);
        o.done = dn;
        o.wrap = wr;
        o.terr = m_terr[k];
    endtask

    // One clock of stimulus driven at negedge; expectation queued for the next posedge.
    task automatic cyc(input bit s, input bit p, input bit c, input bit r = 1'b0);
        pair_t e;
        obs_t  o0, o1;
        @(negedge clk);
        rst = r;
        bus0.start = s; bus0.stop = p; bus0.clear = c; bus0.auto_reload = cur_ar; bus0.target = cur_tgt;
        bus1.start = s; bus1.stop = p; bus1.clear = c; bus1.auto_reload = cur_ar; bus1.target = cur_tgt;
        model_step(0, r, s, p, c, cur_ar, cur_tgt, o0);
        model_step(1, r, s, p, c, cur_ar, cur_tgt, o1);
        e[0] = o0; e[1] = o1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Outputs must drop to zero as soon as rst rises, without a clock edge.
    task automatic check_async_zero(input string tag);
        logic [14:0] a0, a1;
        a0 = {bus0.q3, bus0.q2, bus0.q1, bus0.busy, bus0.done, bus0.wrap};
        a1 = {bus1.q3, bus1.q2, bus1.q1, bus1.busy, bus1.done, bus1.wrap};
        checks++;
        if (a0 !== 15'd0 || a1 !== 15'd0) begin
            errors++;
            $display("FAIL %s async reset: dut0 got %h dut1 got %h, required 0", tag, a0, a1);
        end
    endtask

    task automatic rst_pulse(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_async_zero(tag);
        model_reset(0);
        model_reset(1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
    endtask

    // Monitor: compares each post-edge observation against the queued expectation.
    initial begin
        pair_t e;
        obs_t  a [2];
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a[0] = {bus0.q3, bus0.q2, bus0.q1, bus0.busy, bus0.done, bus0.wrap, bus0.target_err};
                a[1] = {bus1.q3, bus1.q2, bus1.q1, bus1.busy, bus1.done, bus1.wrap, bus1.target_err};
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (a[k] !== e[k]) begin
                        errors++;
                        $display("FAIL dut%0d cycle %0d: got q=%h busy=%b done=%b wrap=%b terr=%b, required q=%h busy=%b done=%b wrap=%b terr=%b",
                                 k, cycle_no, a[k].q, a[k].busy, a[k].done, a[k].wrap, a[k].terr,
                                 e[k].q, e[k].busy, e[k].done, e[k].wrap, e[k].terr);
                    end
                end
            end
        end
    end

    // Bound on total run time.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        bus0.start = 0; bus0.stop = 0; bus0.clear = 0; bus0.auto_reload = 0; bus0.target = '0;
        bus1.start = 0; bus1.stop = 0; bus1.clear = 0; bus1.auto_reload = 0; bus1.target = '0;
        model_reset(0);
        model_reset(1);
        #3;
        check_async_zero("power-on");
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        idle(2);

        // Count to 005 and halt.
        cur_tgt = 12'h005; cur_ar = 0;
        idle(1);
        cyc(1, 0, 0);
        idle(14);

        // Illegal target: start ignored.
        cur_tgt = 12'h0A0;
        idle(1);
        cyc(1, 0, 0); cyc(1, 0, 0);
        idle(2);

        // Carry 009 -> 010 (30 RUN cycles on the prescaled counter).
        cur_tgt = 12'h010;
        idle(1);
        cyc(1, 0, 0);
        idle(40);

        // Hold at 999, then target 000 matches on the rollover with wrap.
        cur_tgt = 12'h999;
        cyc(1, 0, 0);
        idle(3010);
        cur_tgt = 12'h000;
        cyc(1, 0, 0);
        idle(3010);

        // Pause/resume/clear priority.
        cur_tgt = 12'h999;
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        idle(42);
        cyc(1, 1, 0);
        idle(3);
        cyc(1, 0, 0);
        idle(3);
        cyc(1, 0, 1);
        idle(2);

        // Auto-reload sequence, then reset in the middle of counting.
        cur_tgt = 12'h002; cur_ar = 1;
        cyc(1, 0, 0);
        idle(12);
        rst_pulse("mid-run");

        // Target lowered below the current count mid-run.
        cur_ar = 0; cur_tgt = 12'h999;
        cyc(1, 0, 0);
        idle(60);
        cur_tgt = 12'h010;
        idle(3100);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit s, p, c;
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 2))
                    0: cur_tgt = to_bcd(int'($urandom_range(0, 30)));
                    1: cur_tgt = to_bcd(int'($urandom_range(0, 999)));
                    default: cur_tgt = {4'($urandom_range(0, 9)), 4'($urandom_range(10, 15)), 4'($urandom_range(0, 9))};
                endcase
            end
            if ($urandom_range(0, 99) == 0) cur_ar = ~cur_ar;
            if ($urandom_range(0, 399) == 0) begin
                rst_pulse("random");
            end else begin
                s = ($urandom_range(0, 3) == 0);
                p = ($urandom_range(0, 15) == 0);
                c = ($urandom_range(0, 63) == 0);
                cyc(s, p, c);
            end
        end

        idle(3);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter999_ctrl.md
COUNTER999_CTRL -- requirements
Module: counter999_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, meaning RUN-state clock cycles per count increment (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  level-sampled command: begin or resume counting.
REQ-005 SHALL have port stop  input  1  level-sampled command: pause counting.
REQ-006 SHALL have port clear  input  1  synchronous clear to IDLE.
REQ-007 SHALL have port auto_reload  input  1  1 = restart at 000 after target hit; 0 = halt in DONE.
REQ-008 SHALL have port target  input  12  BCD terminal value {hundreds, tens, units}, 4 bits per digit.
REQ-009 SHALL have port q1, q2, q3  output  4 each  units, tens and hundreds BCD digits, registered.
REQ-010 SHALL have port busy  output  1  high in RUN and PAUSE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the count reaches target.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse on the 999 -> 000 rollover.
REQ-013 SHALL have port target_err  output  1  registered; high while any target digit is greater than 9.

Function
REQ-014 SHALL implement four states: IDLE, RUN, PAUSE, DONE.
REQ-015 Command priority SHALL be clear > stop > start whenever commands are asserted in the same cycle.
REQ-016 clear SHALL, from any state, go to IDLE, zero the digits and the prescaler, and suppress done/wrap in that cycle.
REQ-017 IDLE or DONE with start=1 and target_err=0 SHALL go to RUN next cycle, digits loaded to 000, prescaler 0.
REQ-018 start SHALL be ignored while target_err=1 (state unchanged).
REQ-019 RUN with stop=1 SHALL go to PAUSE next cycle; digits and prescaler hold.
REQ-020 PAUSE with start=1 and stop=0 SHALL return to RUN, resuming without clearing digits or prescaler.
REQ-021 In RUN the prescaler SHALL count 0..PRESCALE-1; a tick occurs in the cycle it equals PRESCALE-1, after which it returns to 0.
REQ-022 On each tick, units SHALL increment; 9 -> 0 carries into tens; tens 9 -> 0 carries into hundreds; 999 -> 000 asserts wrap.
REQ-023 Digits SHALL never hold a value above 9.
REQ-024 Target comparison SHALL apply to the post-increment value only, never to the 000 loaded by start.
REQ-025 On match, done SHALL pulse in the same cycle the digits update to target; with auto_reload=0 go to DONE holding the count; with auto_reload=1 load 000 on the next tick and stay in RUN.
REQ-026 target=000 SHALL match on the 999 -> 000 rollover; done and wrap SHALL both pulse in that cycle.
REQ-027 Changing target while in RUN SHALL take effect on the next comparison; if the count already exceeds the new target, counting SHALL continue to the 999 rollover.
REQ-028 Latency with PRESCALE=1: start asserted at edge n gives RUN at n+1 and count 001 at n+2.

Reset
REQ-029 rst=1 SHALL immediately (asynchronously) force IDLE, q1=q2=q3=0, prescaler=0, busy=0, done=0 and wrap=0; target_err SHALL reflect target on the first clock edge after release.
REQ-030 rst asserted mid-RUN SHALL abandon the count; no done or wrap pulse is generated.

Verification
REQ-031 PRESCALE=1, target=0x005, auto_reload=0, start pulse -> digits 001..005 on consecutive cycles, done one cycle with 005, DONE state, busy=0, count held at 005.
REQ-032 PRESCALE=3, target=0x010 -> one increment every 3 cycles; 009 -> 010 carry; done after 30 RUN cycles.
REQ-033 target=0x999, auto_reload=0 -> done at 999, hold; then target=0x000 and start -> done and wrap pulse together at the 999 -> 000 rollover.
REQ-034 Run to 042, assert stop and start together -> PAUSE; start alone -> resume with 043 on the next tick; assert clear with start -> IDLE at 000.
REQ-035 target=0x0A0 -> target_err=1; start ignored, state remains IDLE.
REQ-036 auto_reload=1, target=0x002, PRESCALE=1 -> sequence 001, 002(done), 000, 001, 002(done); busy stays 1; rst pulse mid-count -> immediate 000/IDLE.
